wb_rr_arbiter: RTL and testbench

Two-master, one-slave Wishbone arbiter that shares a single slave bus, such as the I/O controller port, between the MIPS instruction-fetch and data-access masters. It grants the bus per Wishbone cycle (`cyc`) with round-robin fairness and routes the granted master's signals to the slave. A watchdog raises `err` to the owning master if the slave never acknowledges.

---
 rtl/wb_arb_pkg.sv | 28 ++
 rtl/wb_arb_watchdog.sv | 37 +++
 rtl/wb_rr_arbiter.sv | 136 +++++++++++++
 tb/tb_wb_rr_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and widths for the two-master round-robin Wishbone arbiter.
package wb_arb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BUSY0 = 2'd1,
        ARB_BUSY1 = 2'd2
    } arb_state_t;

    // Everything a master drives towards the slave, bundled so the grant mux is one assignment.
    typedef struct packed {
        logic [WB_ADR_W-1:0] adr;
        logic [WB_DAT_W-1:0] dat;
        logic                we;
        logic [WB_SEL_W-1:0] sel;
        logic                cyc;
        logic                stb;
    } wb_req_t;

    function automatic arb_state_t busy_state(input logic idx);
        return idx ? ARB_BUSY1 : ARB_BUSY0;
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Slave-acknowledge watchdog: pulses timeout for one cycle when a strobe waits
// TIMEOUT cycles without an ack.
module wb_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic stb,
    input  logic ack,
    output logic timeout
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] count;
    logic       expire;

    // An ack in the expiry cycle wins; an ownership change never expires.
    assign expire = stb && !ack && !clr && (count == LIMIT);

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count   <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= expire;
            if (clr || ack || !stb || expire) begin
                count <= '0;
            end else begin
                count <= count + 8'd1;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master, one-slave Wishbone arbiter: per-cycle round-robin grant, combinational
// routing to the slave, and a watchdog error back to the owning master.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic [WB_ADR_W-1:0] m0_adr_i,
    input  logic [WB_DAT_W-1:0] m0_dat_i,
    input  logic                m0_we_i,
    input  logic [WB_SEL_W-1:0] m0_sel_i,
    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    output logic [WB_DAT_W-1:0] m0_dat_o,
    output logic                m0_ack_o,
    output logic                m0_err_o,

    input  logic [WB_ADR_W-1:0] m1_adr_i,
    input  logic [WB_DAT_W-1:0] m1_dat_i,
    input  logic                m1_we_i,
    input  logic [WB_SEL_W-1:0] m1_sel_i,
    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    output logic [WB_DAT_W-1:0] m1_dat_o,
    output logic                m1_ack_o,
    output logic                m1_err_o,

    output logic [WB_ADR_W-1:0] s_adr_o,
    output logic [WB_DAT_W-1:0] s_dat_o,
    output logic                s_we_o,
    output logic [WB_SEL_W-1:0] s_sel_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    input  logic [WB_DAT_W-1:0] s_dat_i,
    input  logic                s_ack_i
);

    arb_state_t state;
    arb_state_t state_next;
    logic       last_r;
    wb_req_t    req0;
    wb_req_t    req1;
    wb_req_t    grant_req;
    logic       timeout;

    assign req0 = {m0_adr_i, m0_dat_i, m0_we_i, m0_sel_i, m0_cyc_i, m0_stb_i};
    assign req1 = {m1_adr_i, m1_dat_i, m1_we_i, m1_sel_i, m1_cyc_i, m1_stb_i};

    // State register; last_r records who was served when an owner lets go.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= ARB_IDLE;
            last_r <= 1'b1;
        end else begin
            state <= state_next;
            if (state == ARB_BUSY0 && !m0_cyc_i) begin
                last_r <= 1'b0;
            end else if (state == ARB_BUSY1 && !m1_cyc_i) begin
                last_r <= 1'b1;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_next = busy_state(!last_r);
                end else if (m0_cyc_i) begin
                    state_next = ARB_BUSY0;
                end else if (m1_cyc_i) begin
                    state_next = ARB_BUSY1;
                end
            end
            ARB_BUSY0: begin
                if (!m0_cyc_i) begin
                    state_next = m1_cyc_i ? ARB_BUSY1 : ARB_IDLE;
                end
            end
            ARB_BUSY1: begin
                if (!m1_cyc_i) begin
                    state_next = m0_cyc_i ? ARB_BUSY0 : ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        grant_req = '0;
        m0_ack_o  = 1'b0;
        m1_ack_o  = 1'b0;
        case (state)
            ARB_BUSY0: begin
                grant_req = req0;
                m0_ack_o  = s_ack_i;
            end
            ARB_BUSY1: begin
                grant_req = req1;
                m1_ack_o  = s_ack_i;
            end
            default: ;
        endcase
    end

    assign s_adr_o  = grant_req.adr;
    assign s_dat_o  = grant_req.dat;
    assign s_we_o   = grant_req.we;
    assign s_sel_o  = grant_req.sel;
    assign s_cyc_o  = grant_req.cyc;
    assign s_stb_o  = grant_req.stb;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr     (state_next != state),
        .stb     (s_stb_o),
        .ack     (s_ack_i),
        .timeout (timeout)
    );

    // A pulse never fires across an ownership change, so the current owner is the one that timed out.
    assign m0_err_o = timeout && (state == ARB_BUSY0);
    assign m1_err_o = timeout && (state == ARB_BUSY1);

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: vector table, directed corner cases,
// then randomized traffic against a behavioural ownership/watchdog model.
module tb_wb_rr_arbiter;

    localparam int TMO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic        m_we  [2];
    logic [3:0]  m_sel [2];
    logic        m_cyc [2];
    logic        m_stb [2];
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic        s_we_o, s_cyc_o, s_stb_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i;

    int tests = 0;
    int fails = 0;

    wb_rr_arbiter #(.TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_we_i(m_we[0]), .m0_sel_i(m_sel[0]),
        .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_we_i(m_we[1]), .m1_sel_i(m_sel[1]),
        .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_ctl(input logic c0, input logic s0, input logic c1, input logic s1,
                           input logic ack);
        m_cyc[0] = c0;
        m_stb[0] = s0;
        m_cyc[1] = c1;
        m_stb[1] = s1;
        s_ack_i  = ack;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #2;
    endtask

    // Table rows: inputs for one cycle, expected owner (-1 none) and comb outputs that cycle.
    typedef struct {
        logic c0, s0, c1, s1, ack;
        int   owner;
        logic exp_cyc, exp_ack0, exp_ack1;
    } vec_t;

    vec_t tbl [13];

    // Behavioural model: owner index, last served, watchdog wait count, expected err.
    int   mdl_own, mdl_last, mdl_cnt;
    logic mdl_e0, mdl_e1;

    task automatic model_reset();
        mdl_own  = -1;
        mdl_last = 1;
        mdl_cnt  = 0;
        mdl_e0   = 1'b0;
        mdl_e1   = 1'b0;
    endtask

    task automatic model_step();
        int   prev;
        logic stb_s;
        prev  = mdl_own;
        stb_s = (mdl_own >= 0) ? m_stb[mdl_own] : 1'b0;
        if (mdl_own < 0) begin
            if (m_cyc[0] && m_cyc[1]) mdl_own = 1 - mdl_last;
            else if (m_cyc[0])        mdl_own = 0;
            else if (m_cyc[1])        mdl_own = 1;
        end else if (!m_cyc[mdl_own]) begin
            mdl_last = mdl_own;
            mdl_own  = m_cyc[1 - mdl_own] ? 1 - mdl_last : -1;
        end
        mdl_e0 = 1'b0;
        mdl_e1 = 1'b0;
        if (mdl_own != prev || s_ack_i || !stb_s) begin
            mdl_cnt = 0;
        end else if (mdl_cnt == TMO - 1) begin
            mdl_cnt = 0;
            if (prev == 0) mdl_e0 = 1'b1;
            else           mdl_e1 = 1'b1;
        end else begin
            mdl_cnt++;
        end
    endtask

    initial begin
        logic [31:0] wvals [3];
        logic [31:0] exp_adr, exp_dat;
        logic [3:0]  exp_sel;
        logic        exp_we, exp_cyc, exp_stb, exp_a0, exp_a1;

        tbl[0]  = '{1, 1, 1, 1, 0, -1, 0, 0, 0};
        tbl[1]  = '{1, 1, 1, 1, 1,  0, 1, 1, 0};
        tbl[2]  = '{0, 0, 1, 1, 0,  0, 0, 0, 0};
        tbl[3]  = '{1, 1, 1, 1, 1,  1, 1, 0, 1};
        tbl[4]  = '{1, 1, 1, 1, 0,  1, 1, 0, 0};
        tbl[5]  = '{1, 1, 0, 0, 0,  1, 0, 0, 0};
        tbl[6]  = '{1, 1, 1, 1, 1,  0, 1, 1, 0};
        tbl[7]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0};
        tbl[8]  = '{1, 1, 1, 1, 0, -1, 0, 0, 0};
        tbl[9]  = '{1, 1, 1, 1, 0,  1, 1, 0, 0};
        tbl[10] = '{1, 1, 0, 0, 0,  1, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 0,  0, 0, 0, 0};
        tbl[12] = '{0, 0, 0, 0, 0, -1, 0, 0, 0};

        // Reset state: outputs must be quiet even with both masters requesting.
        m_adr[0] = 32'h800; m_adr[1] = 32'h900;
        m_dat[0] = 32'h0;   m_dat[1] = 32'h0;
        m_we[0]  = 1'b0;    m_we[1]  = 1'b0;
        m_sel[0] = 4'hF;    m_sel[1] = 4'h3;
        s_dat_i  = 32'h0;
        set_ctl(1, 1, 1, 1, 1);
        #12;
        check("rst s_cyc", 32'(s_cyc_o), 0);
        check("rst s_stb", 32'(s_stb_o), 0);
        check("rst s_adr", s_adr_o, 0);
        check("rst ack0", 32'(m0_ack_o), 0);
        check("rst ack1", 32'(m1_ack_o), 0);
        check("rst err0", 32'(m0_err_o), 0);
        check("rst err1", 32'(m1_err_o), 0);
        set_ctl(0, 0, 0, 0, 0);
        next_cycle();
        rst_i = 1'b0;

        // Arbitration table: tie after reset, back-to-back handover, alternating ties.
        for (int i = 0; i < 13; i++) begin
            set_ctl(tbl[i].c0, tbl[i].s0, tbl[i].c1, tbl[i].s1, tbl[i].ack);
            #1;
            exp_adr = (tbl[i].owner < 0) ? 32'h0 : m_adr[tbl[i].owner];
            check($sformatf("tbl%0d s_adr", i), s_adr_o, exp_adr);
            check($sformatf("tbl%0d s_cyc", i), 32'(s_cyc_o), 32'(tbl[i].exp_cyc));
            check($sformatf("tbl%0d s_stb", i), 32'(s_stb_o), 32'(tbl[i].exp_cyc));
            check($sformatf("tbl%0d ack0", i), 32'(m0_ack_o), 32'(tbl[i].exp_ack0));
            check($sformatf("tbl%0d ack1", i), 32'(m1_ack_o), 32'(tbl[i].exp_ack1));
            next_cycle();
            check($sformatf("tbl%0d err", i), {30'h0, m1_err_o, m0_err_o}, 0);
        end

        // Single master read.
        set_ctl(1, 1, 0, 0, 0);
        #1;
        check("single pre s_cyc", 32'(s_cyc_o), 0);
        next_cycle();
        check("single s_cyc", 32'(s_cyc_o), 1);
        check("single s_adr", s_adr_o, 32'h800);
        check("single s_we", 32'(s_we_o), 0);
        s_dat_i = 32'h000000A5;
        s_ack_i = 1'b1;
        #1;
        check("single ack0", 32'(m0_ack_o), 1);
        check("single dat0", m0_dat_o, 32'h000000A5);
        check("single ack1", 32'(m1_ack_o), 0);
        check("single dat1", m1_dat_o, 32'h000000A5);
        set_ctl(0, 0, 0, 0, 0);
        next_cycle();
        check("single idle s_cyc", 32'(s_cyc_o), 0);

        // Locked cycle: m1 keeps the bus for three writes while m0 waits.
        wvals[0] = 32'h11; wvals[1] = 32'h22; wvals[2] = 32'h33;
        m_we[1] = 1'b1;
        set_ctl(0, 0, 1, 1, 0);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            m_dat[1] = wvals[i];
            set_ctl(1, 1, 1, 1, 1);
            #1;
            check($sformatf("lock%0d s_dat", i), s_dat_o, wvals[i]);
            check($sformatf("lock%0d s_adr", i), s_adr_o, 32'h900);
            check($sformatf("lock%0d s_we", i), 32'(s_we_o), 1);
            check($sformatf("lock%0d ack", i), {30'h0, m1_ack_o, m0_ack_o}, 2);
            next_cycle();
        end
        set_ctl(1, 1, 0, 0, 1);
        #1;
        check("lock release s_cyc", 32'(s_cyc_o), 0);
        check("lock release ack0", 32'(m0_ack_o), 0);
        s_ack_i = 1'b0;
        next_cycle();
        check("lock handover s_adr", s_adr_o, 32'h800);
        check("lock handover s_cyc", 32'(s_cyc_o), 1);
        check("lock handover s_we", 32'(s_we_o), 0);
        set_ctl(0, 0, 0, 0, 0);
        m_we[1] = 1'b0;
        next_cycle();

        // Timeout: err pulse in the 5th owned cycle, ownership kept.
        set_ctl(1, 1, 0, 0, 0);
        next_cycle();
        for (int i = 0; i < TMO; i++) begin
            check($sformatf("tmo c%0d err0", i), 32'(m0_err_o), 0);
            check($sformatf("tmo c%0d s_cyc", i), 32'(s_cyc_o), 1);
            next_cycle();
        end
        check("tmo pulse err0", 32'(m0_err_o), 1);
        check("tmo pulse err1", 32'(m1_err_o), 0);
        next_cycle();
        check("tmo after err0", 32'(m0_err_o), 0);
        check("tmo still owned", 32'(s_cyc_o), 1);
        set_ctl(0, 0, 0, 0, 0);
        next_cycle();

        // Ack in the expiry cycle wins over the timeout.
        set_ctl(1, 1, 0, 0, 0);
        next_cycle();
        for (int i = 0; i < TMO - 1; i++) next_cycle();
        s_ack_i = 1'b1;
        #1;
        check("race ack0", 32'(m0_ack_o), 1);
        next_cycle();
        check("race err0", 32'(m0_err_o), 0);
        set_ctl(0, 0, 0, 0, 0);
        next_cycle();

        // Reset mid-transfer in BUSY1 with an err pending.
        set_ctl(0, 0, 1, 1, 0);
        next_cycle();
        for (int i = 0; i < TMO; i++) next_cycle();
        check("midrst err1 before", 32'(m1_err_o), 1);
        #1;
        rst_i = 1'b1;
        #1;
        check("midrst s_cyc", 32'(s_cyc_o), 0);
        check("midrst s_stb", 32'(s_stb_o), 0);
        check("midrst err1", 32'(m1_err_o), 0);
        #3;
        rst_i = 1'b0;
        set_ctl(1, 1, 1, 1, 0);
        next_cycle();
        check("midrst tie s_adr", s_adr_o, 32'h800);
        set_ctl(0, 0, 0, 0, 0);
        next_cycle();

        // Randomized traffic against the behavioural model.
        rst_i = 1'b1;
        #1;
        rst_i = 1'b0;
        model_reset();
        for (int n = 0; n < 600; n++) begin
            for (int m = 0; m < 2; m++) begin
                if ($urandom_range(3) == 0) m_cyc[m] = ~m_cyc[m];
                m_stb[m] = ($urandom_range(3) != 0);
                m_we[m]  = 1'($urandom_range(1));
                m_adr[m] = $urandom;
                m_dat[m] = $urandom;
                m_sel[m] = 4'($urandom_range(15));
            end
            s_dat_i = $urandom;
            s_ack_i = ($urandom_range(3) == 0);
            #1;
            exp_a0 = 1'b0;
            exp_a1 = 1'b0;
            if (mdl_own >= 0) begin
                exp_adr = m_adr[mdl_own];
                exp_dat = m_dat[mdl_own];
                exp_we  = m_we[mdl_own];
                exp_sel = m_sel[mdl_own];
                exp_cyc = m_cyc[mdl_own];
                exp_stb = m_stb[mdl_own];
                if (mdl_own == 0) exp_a0 = s_ack_i;
                else              exp_a1 = s_ack_i;
            end else begin
                exp_adr = 32'h0;
                exp_dat = 32'h0;
                exp_we  = 1'b0;
                exp_sel = 4'h0;
                exp_cyc = 1'b0;
                exp_stb = 1'b0;
            end
            check("rnd s_adr", s_adr_o, exp_adr);
            check("rnd s_dat", s_dat_o, exp_dat);
            check("rnd s_we", 32'(s_we_o), 32'(exp_we));
            check("rnd s_sel", 32'(s_sel_o), 32'(exp_sel));
            check("rnd s_cyc", 32'(s_cyc_o), 32'(exp_cyc));
            check("rnd s_stb", 32'(s_stb_o), 32'(exp_stb));
            check("rnd ack0", 32'(m0_ack_o), 32'(exp_a0));
            check("rnd ack1", 32'(m1_ack_o), 32'(exp_a1));
            check("rnd dat0", m0_dat_o, s_dat_i);
            check("rnd dat1", m1_dat_o, s_dat_i);
            @(posedge clk_i);
            model_step();
            #2;
            check("rnd err0", 32'(m0_err_o), 32'(mdl_e0));
            check("rnd err1", 32'(m1_err_o), 32'(mdl_e1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
